// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side slot demultiplexer for a two-channel TDM word stream.
//
// A transmitter interleaves two WIDTH-bit channels on one bus and tags each channel-0
// word with SYNC. This block tracks the slot sequence and splits the stream into two
// registered channel outputs. It also reports per-channel strobes, frame completion,
// lock status and slot errors, and keeps a wrapping count of completed frames.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   d_i       muxed data word
//   dv_i      d_i valid this cycle
//   sync_i    marks d_i as the slot-0 word (ignored when dv_i=0)
//   o0_o      last channel-0 word
//   o1_o      last channel-1 word
//   v0_o      one-cycle strobe, o0_o updated
//   v1_o      one-cycle strobe, o1_o updated
//   pair_o    one-cycle strobe, slot 0 followed by slot 1 completed
//   lock_o    slot alignment held
//   err_o     one-cycle strobe, slot/sync mismatch
//   frames_o  completed-frame count, wraps modulo 2^CNT_W
module tdm_demux4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             dv_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] o0_o,
  output logic [WIDTH-1:0] o1_o,
  output logic             v0_o,
  output logic             v1_o,
  output logic             pair_o,
  output logic             lock_o,
  output logic             err_o,
  output logic [CNT_W-1:0] frames_o
);

  // StExp1: slot 1 expected next; StExp0: slot 0 expected next.
  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StExp1 = 2'd1,
    StExp0 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] o0_q, o0_d;
  logic [WIDTH-1:0] o1_q, o1_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic             pair_q, pair_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  always_comb begin
    state_d  = state_q;
    o0_d     = o0_q;
    o1_d     = o1_q;
    v0_d     = 1'b0;
    v1_d     = 1'b0;
    pair_d   = 1'b0;
    err_d    = 1'b0;
    frames_d = frames_q;

    // Idle gaps (dv_i=0) hold all state; sync_i alone is meaningless.
    if (dv_i) begin
      unique case (state_q)
        StHunt: begin
          // Untagged words while hunting are silently dropped.
          if (sync_i) begin
            o0_d    = d_i;
            v0_d    = 1'b1;
            state_d = StExp1;
          end
        end
        StExp1: begin
          if (sync_i) begin
            // Duplicate slot 0: flag it but take the newer word as a re-sync.
            o0_d  = d_i;
            v0_d  = 1'b1;
            err_d = 1'b1;
          end else begin
            o1_d     = d_i;
            v1_d     = 1'b1;
            pair_d   = 1'b1;
            frames_d = frames_q + CNT_W'(1);
            state_d  = StExp0;
          end
        end
        StExp0: begin
          if (sync_i) begin
            o0_d    = d_i;
            v0_d    = 1'b1;
            state_d = StExp1;
          end else begin
            // Missing sync: alignment is lost, drop the word and hunt again.
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end

    lock_d = (state_d != StHunt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StHunt;
      o0_q     <= '0;
      o1_q     <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      pair_q   <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      o0_q     <= o0_d;
      o1_q     <= o1_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      pair_q   <= pair_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      frames_q <= frames_d;
    end
  end

  assign o0_o     = o0_q;
  assign o1_o     = o1_q;
  assign v0_o     = v0_q;
  assign v1_o     = v1_q;
  assign pair_o   = pair_q;
  assign lock_o   = lock_q;
  assign err_o    = err_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 with hand-computed expected values.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic       dv;
  logic       sync;
  logic [3:0] o0;
  logic [3:0] o1;
  logic       v0;
  logic       v1;
  logic       pair;
  logic       lock;
  logic       err;
  logic [7:0] frames;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  tdm_demux4 #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (d),
    .dv_i    (dv),
    .sync_i  (sync),
    .o0_o    (o0),
    .o1_o    (o1),
    .v0_o    (v0),
    .v1_o    (v1),
    .pair_o  (pair),
    .lock_o  (lock),
    .err_o   (err),
    .frames_o(frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] dd, input logic ddv, input logic dsync);
    d    = dd;
    dv   = ddv;
    sync = dsync;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    dv    = 1'b0;
    sync  = 1'b0;
    d     = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Strobes: {v0, v1, pair, err}
  task automatic check_strobes(input string tag, input logic [3:0] exp);
    check(tag, 32'({v0, v1, pair, err}), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    dv    = 1'b0;
    sync  = 1'b0;
    d     = 4'd0;

    // Reset then idle.
    repeat (10) @(posedge clk);
    #1;
    check("rst_o0", 32'(o0), 0);
    check("rst_o1", 32'(o1), 0);
    check_strobes("rst_strb", 4'b0000);
    check("rst_lock", 32'(lock), 0);
    check("rst_frames", 32'(frames), 0);
    rst_n = 1'b1;
    idle(5);
    check("idle_o0o1", 32'({o0, o1}), 0);
    check_strobes("idle_strb", 4'b0000);
    check("idle_lock", 32'(lock), 0);
    check("idle_frames", 32'(frames), 0);

    // Nominal frame.
    step(4'd7, 1'b1, 1'b1);
    check("nom_o0", 32'(o0), 7);
    check_strobes("nom_s0_strb", 4'b1000);
    check("nom_s0_lock", 32'(lock), 1);
    step(4'd8, 1'b1, 1'b0);
    check("nom_o1", 32'(o1), 8);
    check("nom_o0_hold", 32'(o0), 7);
    check_strobes("nom_s1_strb", 4'b0110);
    check("nom_frames", 32'(frames), 1);
    check("nom_lock", 32'(lock), 1);
    idle(1);
    check_strobes("nom_after_strb", 4'b0000);

    // SYNC without DV is ignored.
    step(4'd3, 1'b0, 1'b1);
    check_strobes("syncnodv_strb", 4'b0000);
    check("syncnodv_o0", 32'(o0), 7);
    check("syncnodv_lock", 32'(lock), 1);

    // Gaps and hunt.
    do_reset();
    step(4'd3, 1'b1, 1'b0);
    check_strobes("hunt_drop1_strb", 4'b0000);
    check("hunt_drop1_lock", 32'(lock), 0);
    step(4'd5, 1'b1, 1'b0);
    check_strobes("hunt_drop2_strb", 4'b0000);
    check("hunt_drop_o", 32'({o0, o1}), 0);
    step(4'd7, 1'b1, 1'b1);
    check("hunt_o0", 32'(o0), 7);
    check_strobes("hunt_s0_strb", 4'b1000);
    idle(2);
    check_strobes("hunt_gap_strb", 4'b0000);
    check("hunt_gap_lock", 32'(lock), 1);
    check("hunt_gap_o0", 32'(o0), 7);
    step(4'd8, 1'b1, 1'b0);
    check("hunt_o1", 32'(o1), 8);
    check_strobes("hunt_s1_strb", 4'b0110);
    check("hunt_frames", 32'(frames), 1);

    // Duplicate sync.
    do_reset();
    step(4'd7, 1'b1, 1'b1);
    step(4'd9, 1'b1, 1'b1);
    check("dup_o0", 32'(o0), 9);
    check_strobes("dup_strb", 4'b1001);
    check("dup_lock", 32'(lock), 1);
    check("dup_frames", 32'(frames), 0);
    step(4'd8, 1'b1, 1'b0);
    check("dup_o1", 32'(o1), 8);
    check_strobes("dup_s1_strb", 4'b0110);
    check("dup_frames2", 32'(frames), 1);

    // Missing sync (continues from the completed frame above).
    step(4'd4, 1'b1, 1'b0);
    check_strobes("miss_strb", 4'b0001);
    check("miss_lock", 32'(lock), 0);
    check("miss_o0o1", 32'({o0, o1}), 32'h98);
    step(4'd7, 1'b1, 1'b1);
    check("relock_lock", 32'(lock), 1);
    step(4'd8, 1'b1, 1'b0);
    check("relock_frames", 32'(frames), 2);
    check("relock_o0o1", 32'({o0, o1}), 32'h78);

    // Counter wrap over 256 back-to-back frames.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      step(4'(i), 1'b1, 1'b1);
      step(4'(i + 1), 1'b1, 1'b0);
    end
    check("wrap_255", 32'(frames), 255);
    step(4'd2, 1'b1, 1'b1);
    step(4'd6, 1'b1, 1'b0);
    check("wrap_0", 32'(frames), 0);
    check_strobes("wrap_strb", 4'b0110);
    check("wrap_o0o1", 32'({o0, o1}), 32'h26);

    // Asynchronous reset mid-frame, between clock edges.
    step(4'd7, 1'b1, 1'b1);
    check("areset_pre_lock", 32'(lock), 1);
    dv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_o0o1", 32'({o0, o1}), 0);
    check_strobes("areset_strb", 4'b0000);
    check("areset_lock", 32'(lock), 0);
    check("areset_frames", 32'(frames), 0);
    #1;
    rst_n = 1'b1;
    step(4'd8, 1'b1, 1'b0);
    check("areset_drop_o1", 32'(o1), 0);
    check_strobes("areset_drop_strb", 4'b0000);
    check("areset_drop_lock", 32'(lock), 0);
    check("areset_drop_frames", 32'(frames), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
